// File: rtl/control_fsm.sv
// control_fsm: multi-cycle fetch/decode/execute/writeback controller for the 8-bit RISC core.
module control_fsm #(
  parameter logic [7:0] PC_RESET = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        instr_req,
  output logic [7:0]  instr_addr,
  input  logic [15:0] instr_data,
  input  logic        instr_valid,
  input  logic [7:0]  rd_data1,
  output logic [2:0]  rd_addr1,
  output logic [2:0]  rd_addr2,
  output logic [2:0]  wr_addr,
  output logic        we,
  output logic        reg_write_data_select,
  output logic [7:0]  imm,
  output logic [2:0]  alu_op,
  output logic        illegal,
  output logic        halted
);
  typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, WRITEBACK, HALT} state_t;
  state_t      state, state_nx;
  logic [7:0]  pc, pc_nx;
  logic [15:0] ir, ir_nx;
  logic [3:0]  op;
  logic        is_alu, is_wb, is_ill;
  assign op     = ir[15:12];
  assign is_alu = op inside {[4'd1:4'd5]};
  assign is_wb  = op inside {[4'd1:4'd7]};
  assign is_ill = op inside {[4'hA:4'hE]};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= FETCH;
      pc    <= PC_RESET;
      ir    <= '0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      ir    <= ir_nx;
    end
  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    ir_nx    = ir;
    unique case (state)
      FETCH: if (instr_valid) begin
        ir_nx    = instr_data;
        state_nx = DECODE;
      end
      DECODE: state_nx = EXECUTE;
      EXECUTE: begin
        state_nx = is_wb ? WRITEBACK : op == 4'hF ? HALT : FETCH;
        pc_nx    = is_wb || op == 4'hF ? pc
                 : op == 4'h8 ? ir[7:0]
                 : op == 4'h9 && rd_data1 == 8'h00 ? ir[7:0]
                 : pc + 8'd1;
      end
      WRITEBACK: begin
        state_nx = FETCH;
        pc_nx    = pc + 8'd1;
      end
      default: state_nx = HALT;
    endcase
  end
  // Every control output is a pure decode of state and IR, so reset clears them without a clock.
  assign instr_req             = state == FETCH;
  assign instr_addr            = pc;
  assign we                    = state == WRITEBACK;
  assign illegal               = state == EXECUTE && is_ill;
  assign halted                = state == HALT;
  assign rd_addr1              = op == 4'h9 ? ir[11:9] : ir[8:6];
  assign rd_addr2              = ir[5:3];
  assign wr_addr               = ir[11:9];
  assign imm                   = ir[7:0];
  assign reg_write_data_select = op == 4'h6;
  assign alu_op                = is_alu ? op[2:0] - 3'd1 : op == 4'h7 ? 3'd5 : 3'd0;
endmodule

// File: doc/control_fsm.md
# control_fsm

Multi-cycle control state machine for the 8-bit RISC core. It fetches 16-bit instructions over a valid/request handshake, decodes them, and drives the register-file read/write addresses, write enable, write-data select, immediate and ALU opcode. It sits directly upstream of the register file and ALU and is the only source of their control signals. Branch decisions use the register file's read port 1 data.

## Interface
- PC_RESET, 8'h00, program counter value loaded on reset
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- instr_req  out  1  fetch request, high in FETCH
- instr_addr  out  8  fetch address, equals pc
- instr_data  in  16  instruction word, sampled when instr_req and instr_valid are both high
- instr_valid  in  1  instr_data valid; ignored outside FETCH
- rd_data1  in  8  register file read port 1 data, used by BEQZ
- rd_addr1, rd_addr2  out  3 each  register file read addresses
- wr_addr  out  3  register file write address
- we  out  1  register file write enable
- reg_write_data_select  out  1  1 selects immediate, 0 selects ALU result
- imm  out  8  immediate, IR[7:0]
- alu_op  out  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 PASS A
- illegal  out  1  one-cycle pulse on an undefined opcode
- halted  out  1  high in HALT state

## Operation
- Instruction fields: op=IR[15:12], rd=IR[11:9], rs1=IR[8:6], rs2=IR[5:3], imm8=IR[7:0].
- Opcodes:
  - 0 NOP.
  - 1–5 ADD/SUB/AND/OR/XOR rd,rs1,rs2, with alu_op 000–100.
  - 6 LDI rd,imm8.
  - 7 MOV rd,rs1, with alu_op 101.
  - 8 JMP imm8.
  - 9 BEQZ rd,imm8: branch if reg[rd]==0.
  - A–E illegal, executed as NOP.
  - F HALT.
- Registered state: state (FETCH, DECODE, EXECUTE, WRITEBACK, HALT), pc[7:0], IR[15:0].
- Outputs are decoded combinationally from state and IR.
  - rd_addr1 is rs1, except for BEQZ, where it is rd.
  - rd_addr2 is rs2. wr_addr is rd. imm is IR[7:0].
  - alu_op is the table value for opcodes 1–5 and 7, and 000 otherwise.
  - reg_write_data_select is 1 only for LDI.
  - we is high only in WRITEBACK.
- Transitions:
  - FETCH: if instr_valid, IR<=instr_data and go to DECODE; otherwise stay.
  - DECODE always goes to EXECUTE. Read addresses are stable from here on.
  - EXECUTE:
    - Opcodes 1–7 go to WRITEBACK.
    - JMP: pc<=imm8, go to FETCH.
    - BEQZ: pc<=(rd_data1==0)?imm8:pc+1, go to FETCH.
    - NOP and illegal opcodes: pc<=pc+1, go to FETCH. Illegal opcodes also pulse illegal.
    - HALT goes to HALT with pc unchanged.
  - WRITEBACK: we=1, pc<=pc+1, go to FETCH.
  - HALT is terminal until reset.
- pc arithmetic is modulo 256: 8'hFF+1 = 8'h00.

## Timing
- Reset (asynchronous assert, synchronous release with clk):
  - state=FETCH, pc=PC_RESET, IR=16'h0000 (NOP).
  - we=0, illegal=0, halted=0, alu_op=000, all addresses 0, imm=0, reg_write_data_select=0.
  - instr_req=1 from reset.
- Reset asserted mid-instruction clears we in the same cycle, with no clock needed. The pending write is lost.
- Handshake: instr_valid may arrive in the same cycle as instr_req (zero-wait memory). Each wait cycle adds one cycle of latency. instr_addr is held stable while waiting.
- Latency with zero-wait fetch:
  - ALU, LDI and MOV: 4 cycles (F, D, E, W).
  - NOP, JMP, BEQZ and illegal: 3 cycles.
- The register file write takes effect at the rising edge that ends WRITEBACK. Fetch of the next instruction begins on the following cycle.
- rd_data1 is sampled in EXECUTE, so a BEQZ immediately after a write to the same register sees the new value.
- illegal is high for exactly the EXECUTE cycle.

## Test plan
- Reset with PC_RESET=8'h10, then release → instr_addr=8'h10, instr_req=1, we=0, halted=0.
- Load 16'h6A5C (LDI r5,0x5C) with instr_valid held high → we=1 in cycle 4 only, with wr_addr=5, imm=8'h5C, reg_write_data_select=1; then pc increments by 1.
- Load 16'h2298 (SUB r1,r2,r3) with instr_valid delayed 3 cycles → instr_addr held stable; alu_op=001, rd_addr1=2, rd_addr2=3, wr_addr=1; we pulses once, 7 cycles after request.
- Load 16'h9620 (BEQZ r3,0x20) twice, with rd_data1=0 then rd_data1=8'h07 → pc=8'h20 in the first case, pc+1 in the second; we never asserted.
- Run JMP 8'hFF, then NOP → pc wraps to 8'h00. Then load 16'hB000 → illegal pulses for 1 cycle and pc advances.
- Assert rst_n low during WRITEBACK of an ADD → we drops immediately, state=FETCH, pc=PC_RESET. Separately, load 16'hF000 → halted=1, instr_req=0, and the block stays in HALT for 20 cycles.
